// File: rtl/ofmap_drain.sv
//------------------------------------------------------------------------------
// Module      : ofmap_drain
// Description : Drains the accumulation buffer writeback bank into a
//               valid/ready stream through a 2-entry output FIFO.
//               Optional: define OFMAP_DRAIN_LAST_EN to add out_last.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ofmap_drain #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 6,
    parameter int BANK_DEPTH      = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BANK_ADDR_WIDTH:0]   num_words,
    output logic                       ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
    input  logic [DATA_WIDTH-1:0]      rdata_wb,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
`ifdef OFMAP_DRAIN_LAST_EN
    ,
    output logic                       out_last
`endif
);

    localparam int                   CW      = BANK_ADDR_WIDTH + 1;
    localparam int                   AW      = BANK_ADDR_WIDTH;
    localparam logic [CW-1:0]        C_DEPTH = CW'(BANK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           xfer_q;
    logic [AW-1:0]           addr_q;
    logic                    inflight_q;
    logic [1:0]              occ_q;
    logic [DATA_WIDTH-1:0]   head_q;
    logic [DATA_WIDTH-1:0]   tail_q;

    logic                    w_start;
    logic                    w_pop;
    logic [2:0]              w_room;
    logic [CW-1:0]           w_cnt;
    logic                    w_ren;
    logic [AW-1:0]           w_issue_addr;
    logic [CW-1:0]           w_issue_next;
    logic                    w_last_issue;
    logic                    w_last_xfer;

    assign w_start = (state_q == S_IDLE) && start;
    assign w_pop   = (occ_q != 2'd0) && out_ready;
    assign w_cnt   = (num_words > C_DEPTH) ? C_DEPTH : num_words;

    // Credit check uses occupancy after this cycle's pop so a full-rate
    // stream keeps one read in flight and one word queued.
    assign w_room  = {1'b0, occ_q} - {2'b00, w_pop} + {2'b00, inflight_q};

    // The first read goes out in the accept cycle so data appears two
    // cycles after start.
    assign w_ren        = (w_start && (w_cnt != '0)) ||
                          ((state_q == S_READ) && (w_room < 3'd2));
    assign w_issue_addr = w_start ? '0 : (addr_q + AW'(1));
    assign w_issue_next = {1'b0, w_issue_addr} + CW'(1);
    assign w_last_issue = w_ren && (w_issue_next == (w_start ? w_cnt : count_q));
    assign w_last_xfer  = (xfer_q + CW'(1)) == count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            xfer_q     <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= w_ren;
            if (w_ren) begin
                addr_q <= w_issue_addr;
            end

            if (w_start) begin
                xfer_q <= '0;
            end else if (w_pop) begin
                xfer_q <= xfer_q + CW'(1);
            end

            case ({w_pop, inflight_q})
                2'b01: begin
                    if (occ_q == 2'd0) begin
                        head_q <= rdata_wb;
                    end else begin
                        tail_q <= rdata_wb;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b10: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= rdata_wb;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= rdata_wb;
                    end
                end
                default: begin
                end
            endcase

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count_q <= w_cnt;
                        if (w_cnt == '0) begin
                            state_q <= S_DONE;
                        end else if (w_last_issue) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_last_issue) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_pop && w_last_xfer) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ren_wb    = w_ren;
    assign radr_wb   = w_ren ? w_issue_addr : addr_q;
    assign out_data  = head_q;
    assign out_valid = (occ_q != 2'd0);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

`ifdef OFMAP_DRAIN_LAST_EN
    assign out_last  = out_valid && w_last_xfer;
`endif

endmodule

`default_nettype wire
